mmio_bridge: RTL

Bridge between the core's load/store unit and the 11-bit memory-mapped peripheral bus (GPIO port, timers, UART). Accepts one CPU access at a time, issues single-cycle `rdEn`/`wrEn` strobes with a word address and write data, and collects the registered `dataOut`/`outEn` responses from all peripherals. Partial-word stores are performed as read-modify-write. Accesses that get no response are terminated by a timeout with an error flag.

---
 rtl/mmio_pkg.sv | 40 ++++
 rtl/mmio_resp_collect.sv | 33 +++
 rtl/mmio_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge.
//   - mmio_state_e : bridge FSM states
//   - MMIO_ADDR_W  : peripheral word-address width
//   - GPIO_*_ADDR  : well-known peripheral register addresses
//   - mergeLanes   : byte-lane merge used by read-modify-write stores
package mmio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StResp
    } mmio_state_e;

    localparam int unsigned MMIO_ADDR_W = 11;

    localparam logic [MMIO_ADDR_W-1:0] GPIO_DDR_ADDR = 11'h404;
    localparam logic [MMIO_ADDR_W-1:0] GPIO_PVL_ADDR = 11'h405;
    // Reading PIN returns sampled pin levels; writing it toggles DDR bits, so a
    // read-modify-write store here corrupts DDR. Software must use word stores.
    localparam logic [MMIO_ADDR_W-1:0] GPIO_PIN_ADDR = 11'h406;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    // Lane i comes from wdata when be[i] is set, otherwise from the read-back word.
    function automatic logic [31:0] mergeLanes(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_resp_collect.sv
// Combines the registered responses of all peripherals.
//   periph_data in  32*N_PERIPH : packed dataOut of each peripheral
//   periph_en   in  N_PERIPH    : packed outEn of each peripheral
//   hit_data    out 32          : OR of all enabled data words
//   any_hit     out 1           : at least one outEn set
//   multi_hit   out 1           : more than one outEn set (bus contention)
module mmio_resp_collect #(
    parameter int unsigned N_PERIPH = 4
) (
    input  logic [32*N_PERIPH-1:0] periph_data,
    input  logic [N_PERIPH-1:0]    periph_en,
    output logic [31:0]            hit_data,
    output logic                   any_hit,
    output logic                   multi_hit
);

    always_comb begin
        hit_data  = '0;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        for (int i = 0; i < int'(N_PERIPH); i++) begin
            if (periph_en[i]) begin
                hit_data |= periph_data[32*i +: 32];
                // A second hit after the first one marks contention.
                if (any_hit) begin
                    multi_hit = 1'b1;
                end
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Bridge from the load/store unit to the 11-bit MMIO peripheral bus.
// One access at a time; partial stores are done as read-modify-write; accesses
// with no peripheral response are aborted after TIMEOUT wait cycles.
//   clk, rstB                  : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/be   : CPU access request (sampled in IDLE only)
//   cpu_ready/rdata/err        : one-cycle completion pulse with load data / error
//   addr, wrData, wrEn, rdEn   : peripheral bus (registered address and data)
//   periph_data, periph_en     : packed dataOut / outEn of all peripherals
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int unsigned N_PERIPH  = 4,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rstB,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [3:0]             cpu_be,
    output logic                   cpu_ready,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_err,
    output logic [MMIO_ADDR_W-1:0] addr,
    output logic [31:0]            wrData,
    output logic                   wrEn,
    output logic                   rdEn,
    input  logic [32*N_PERIPH-1:0] periph_data,
    input  logic [N_PERIPH-1:0]    periph_en
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    mmio_state_e            stateQ, stateD;
    logic                   weQ, weD;
    logic [3:0]             beQ, beD;
    logic [31:0]            wdataQ, wdataD;
    logic [MMIO_ADDR_W-1:0] addrQ, addrD;
    logic [31:0]            wrDataQ, wrDataD;
    logic [31:0]            rdataQ, rdataD;
    logic                   errQ, errD;
    logic [CntW-1:0]        cntQ, cntD;

    logic [CntW-1:0] cntInc;
    logic            inRegion;
    logic [31:0]     hitData;
    logic            anyHit;
    logic            multiHit;
    logic            unusedAddrBits;

    // Byte offset within the word is irrelevant on a word-addressed bus.
    assign unusedAddrBits = ^cpu_addr[1:0];

    assign inRegion = (cpu_addr[31:13] == MMIO_BASE[31:13]);
    assign cntInc   = cntQ + CntW'(1);

    mmio_resp_collect #(
        .N_PERIPH (N_PERIPH)
    ) uCollect (
        .periph_data (periph_data),
        .periph_en   (periph_en),
        .hit_data    (hitData),
        .any_hit     (anyHit),
        .multi_hit   (multiHit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstB) begin
            stateQ  <= StIdle;
            weQ     <= 1'b0;
            beQ     <= 4'h0;
            wdataQ  <= '0;
            addrQ   <= '0;
            wrDataQ <= '0;
            rdataQ  <= '0;
            errQ    <= 1'b0;
            cntQ    <= '0;
        end else begin
            stateQ  <= stateD;
            weQ     <= weD;
            beQ     <= beD;
            wdataQ  <= wdataD;
            addrQ   <= addrD;
            wrDataQ <= wrDataD;
            rdataQ  <= rdataD;
            errQ    <= errD;
            cntQ    <= cntD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD  = stateQ;
        weD     = weQ;
        beD     = beQ;
        wdataD  = wdataQ;
        addrD   = addrQ;
        wrDataD = wrDataQ;
        rdataD  = rdataQ;
        errD    = errQ;
        cntD    = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (cpu_req) begin
                    weD    = cpu_we;
                    beD    = cpu_be;
                    wdataD = cpu_wdata;
                    addrD  = cpu_addr[12:2];
                    errD   = 1'b0;
                    if (!inRegion) begin
                        errD = 1'b1;
                        // Store data return is never updated, so only loads see all-ones.
                        if (!cpu_we) begin
                            rdataD = '1;
                        end
                        stateD = StResp;
                    end else if (cpu_we && cpu_be == 4'h0) begin
                        stateD = StResp;
                    end else if (cpu_we && cpu_be == 4'hF) begin
                        wrDataD = cpu_wdata;
                        stateD  = StWrite;
                    end else begin
                        stateD = StRead;
                    end
                end
            end
            StRead: begin
                cntD   = '0;
                stateD = StWait;
            end
            StWait: begin
                if (anyHit) begin
                    if (multiHit) begin
                        errD = 1'b1;
                    end
                    if (weQ) begin
                        wrDataD = mergeLanes(wdataQ, hitData, beQ);
                        stateD  = StWrite;
                    end else begin
                        rdataD = hitData;
                        stateD = StResp;
                    end
                end else begin
                    cntD = cntInc;
                    if (cntInc == CntW'(TIMEOUT)) begin
                        errD = 1'b1;
                        if (!weQ) begin
                            rdataD = '1;
                        end
                        stateD = StResp;
                    end
                end
            end
            StWrite: stateD = StResp;
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs: strobes decoded from the registered state, so they are glitch-free.
    always_comb begin
        rdEn      = 1'b0;
        wrEn      = 1'b0;
        cpu_ready = 1'b0;
        unique case (stateQ)
            StRead:  rdEn      = 1'b1;
            StWrite: wrEn      = 1'b1;
            StResp:  cpu_ready = 1'b1;
            default: ;
        endcase
        cpu_err   = cpu_ready & errQ;
        cpu_rdata = rdataQ;
        addr      = addrQ;
        wrData    = wrDataQ;
    end

endmodule
